// File: rtl/des_block_packer.sv
// Byte-stream to 64-bit block packer feeding the DES core, with key/mode staging.
// Define DES_PKCS5_PAD_EN to build PKCS#5 padding (adds the PAD state for boundary messages).
module des_block_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [0:63] key_i,
  input  logic        mode_i,
  input  logic        key_load_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic [0:63] data_o,
  output logic [0:63] key_o,
  output logic        mode_o,
  output logic        valid_o,
  output logic        last_o
);

`ifdef DES_PKCS5_PAD_EN
  typedef enum logic {FILL, PAD} state_t;
  state_t state_q, state_d;
`endif

  logic [0:63] shadow_q, shadow_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [0:63] data_q, data_d;
  logic [0:63] key_pend_q, key_pend_d;
  logic        mode_pend_q, mode_pend_d;
  logic [0:63] key_q, key_d;
  logic        mode_q, mode_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        accept;
  logic        key_load_ok;
  logic [7:0]  fill_byte;
  logic [0:63] block;

`ifdef DES_PKCS5_PAD_EN
  assign byte_ready_o = (state_q == FILL);
  assign fill_byte    = 8'd7 - {5'd0, cnt_q};
  assign key_load_ok  = key_load_i && (cnt_q == 3'd0) && !accept && (state_q == FILL);
`else
  assign byte_ready_o = 1'b1;
  assign fill_byte    = PAD_BYTE;
  assign key_load_ok  = key_load_i && (cnt_q == 3'd0) && !accept;
`endif

  assign accept = byte_valid_i && byte_ready_o;

  // Completed block as it would look if the current byte finished it; unused slots take the fill value.
  always_comb begin
    block = shadow_q;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(cnt_q)) begin
        block[8*i +: 8] = byte_i;
      end else if (i > int'(cnt_q)) begin
        block[8*i +: 8] = fill_byte;
      end
    end
  end

  always_comb begin
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    key_pend_d  = key_pend_q;
    mode_pend_d = mode_pend_q;
    key_d       = key_q;
    mode_d      = mode_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
`ifdef DES_PKCS5_PAD_EN
    state_d     = state_q;
`endif

    if (key_load_ok) begin
      key_pend_d  = key_i;
      mode_pend_d = mode_i;
    end

    if (accept) begin
      if ((cnt_q == 3'd7) || byte_last_i) begin
        data_d  = block;
        valid_d = 1'b1;
        last_d  = byte_last_i;
        key_d   = key_pend_q;
        mode_d  = mode_pend_q;
        cnt_d   = 3'd0;
`ifdef DES_PKCS5_PAD_EN
        // A message ending exactly on a block boundary still owes a full pad block.
        if (byte_last_i && (cnt_q == 3'd7)) begin
          last_d  = 1'b0;
          state_d = PAD;
        end
`endif
      end else begin
        shadow_d[8*cnt_q +: 8] = byte_i;
        cnt_d = cnt_q + 3'd1;
      end
    end

`ifdef DES_PKCS5_PAD_EN
    if (state_q == PAD) begin
      data_d  = {8{8'h08}};
      valid_d = 1'b1;
      last_d  = 1'b1;
      key_d   = key_pend_q;
      mode_d  = mode_pend_q;
      state_d = FILL;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      shadow_q    <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      key_pend_q  <= '0;
      mode_pend_q <= 1'b0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
`ifdef DES_PKCS5_PAD_EN
      state_q     <= FILL;
`endif
    end else begin
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      key_pend_q  <= key_pend_d;
      mode_pend_q <= mode_pend_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
`ifdef DES_PKCS5_PAD_EN
      state_q     <= state_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign key_o   = key_q;
  assign mode_o  = mode_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule
